serial_link_arbiter: RTL

Round-robin arbiter and sequencer sharing one WIDTH-bit D-flip-flop shift chain between two requesters. The winning requester's parallel word is loaded into the chain and shifted out LSB-first, one bit per clock, with a grant pulse, a valid strobe and a completion pulse. It sits between two word producers and a single serial output line, and is the control layer over the plain flip-flop chain.

---
 rtl/serial_link_arbiter_if.sv | 29 ++
 rtl/serial_link_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/serial_link_arbiter_if.sv
// Two-requester serial link bundle: word requests in, grants and a serial bit stream out.
// No logic of its own; it only groups the requester-side and arbiter-side signals.
// The requester side owns req/data/hold; the arbiter side owns every output.
interface serial_link_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             hold;
  logic             gnt0;
  logic             gnt1;
  logic             sout;
  logic             sout_valid;
  logic             owner;
  logic             busy;
  logic             done;

  modport master (
    output req0, req1, data0, data1, hold,
    input  gnt0, gnt1, sout, sout_valid, owner, busy, done
  );

  modport slave (
    input  req0, req1, data0, data1, hold,
    output gnt0, gnt1, sout, sout_valid, owner, busy, done
  );
endinterface

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter that loads the winner's word into one shift chain and sends it LSB-first.
// Latency: grant and first bit one edge after req in IDLE; transfer period WIDTH+2 cycles.
// Backpressure: hold freezes the chain while shifting; requests are only sampled in IDLE.
module serial_link_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_link_arbiter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             last;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             valid_r;
  logic             owner_r;
  logic             busy_r;
  logic             done_r;
  logic             any_req;
  logic             win;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      win = ~last;
    end else begin
      win = bus.req1;
    end
  end

  // Sequencer: arbitrate in IDLE, shift one bit per unheld cycle, one DONE cycle, back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      count   <= '0;
      last    <= 1'b1;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      valid_r <= 1'b0;
      owner_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      // Grants are strictly one-cycle pulses, even if hold arrives right after.
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= SHIFT;
            shreg   <= win ? bus.data1 : bus.data0;
            count   <= '0;
            last    <= win;
            owner_r <= win;
            gnt0_r  <= ~win;
            gnt1_r  <= win;
            busy_r  <= 1'b1;
            valid_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            // Leave count at its final value on the last shift so it never wraps.
            if (count == LAST_CNT) begin
              state   <= DONE;
              valid_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt0_r;
  assign bus.gnt1       = gnt1_r;
  assign bus.sout       = shreg[0];
  assign bus.sout_valid = valid_r;
  assign bus.owner      = owner_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule
